// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one external ALU between two requesters.
// One transaction in flight; results are held per requester until acknowledged.
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] rs0,
    input  logic [DATA_W-1:0] rt0,
    input  logic [DATA_W-1:0] rs1,
    input  logic [DATA_W-1:0] rt1,
    input  logic [3:0]        ctrl0,
    input  logic [3:0]        ctrl1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rsp_valid0,
    output logic              rsp_valid1,
    output logic [DATA_W-1:0] rsp_out0,
    output logic [DATA_W-1:0] rsp_out1,
    output logic              rsp_zero0,
    output logic              rsp_zero1,
    input  logic              rsp_ack0,
    input  logic              rsp_ack1,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_rs,
    output logic [DATA_W-1:0] alu_rt,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t            r_state, w_next;
    logic              r_ptr, r_owner, r_zero0, r_zero1;
    logic [3:0]        r_ctrl;
    logic [DATA_W-1:0] r_rs, r_rt, r_out0, r_out1;
    logic              w_idle, w_gnt0, w_gnt1, w_ack;
    // r_ptr set means requester 1 wins a tie
    assign w_idle = (r_state == IDLE) && !rst;
    assign w_gnt0 = w_idle && req0 && (!req1 || !r_ptr);
    assign w_gnt1 = w_idle && req1 && (!req0 || r_ptr);
    assign w_ack  = r_owner ? rsp_ack1 : rsp_ack0;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_gnt0 || w_gnt1) ? EXEC : IDLE;
            EXEC:    w_next = RESP;
            RESP:    w_next = w_ack ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= 1'b0;
            r_owner <= 1'b0;
            r_ctrl  <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_out0  <= '0;
            r_out1  <= '0;
            r_zero0 <= 1'b0;
            r_zero1 <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_gnt0 || w_gnt1) begin
                r_owner <= w_gnt1;
                r_ptr   <= w_gnt0;
                r_ctrl  <= w_gnt1 ? ctrl1 : ctrl0;
                r_rs    <= w_gnt1 ? rs1 : rs0;
                r_rt    <= w_gnt1 ? rt1 : rt0;
            end
            if (r_state == EXEC && !r_owner) begin
                r_out0  <= alu_out;
                r_zero0 <= alu_zero;
            end
            if (r_state == EXEC && r_owner) begin
                r_out1  <= alu_out;
                r_zero1 <= alu_zero;
            end
        end
    end
    assign gnt0       = w_gnt0;
    assign gnt1       = w_gnt1;
    assign rsp_valid0 = (r_state == RESP) && !r_owner;
    assign rsp_valid1 = (r_state == RESP) && r_owner;
    assign rsp_out0   = r_out0;
    assign rsp_out1   = r_out1;
    assign rsp_zero0  = r_zero0;
    assign rsp_zero1  = r_zero1;
    assign alu_ctrl   = r_ctrl;
    assign alu_rs     = r_rs;
    assign alu_rt     = r_rt;
    assign busy       = r_state != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a
// transaction-level model with a behavioural ALU attached to the shared port.
module tb_alu_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req0 = 0, req1 = 0, rsp_ack0 = 0, rsp_ack1 = 0;
    logic [31:0] rs0 = 0, rt0 = 0, rs1 = 0, rt1 = 0;
    logic [3:0]  ctrl0 = 0, ctrl1 = 0;
    logic        gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_zero0, rsp_zero1, busy, alu_zero;
    logic [31:0] rsp_out0, rsp_out1, alu_rs, alu_rt, alu_out;
    logic [3:0]  alu_ctrl;
    int          n_chk = 0, n_fail = 0;

    alu_arbiter #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .rs0(rs0), .rt0(rt0), .rs1(rs1), .rt1(rt1), .ctrl0(ctrl0), .ctrl1(ctrl1),
        .gnt0(gnt0), .gnt1(gnt1), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_out0(rsp_out0), .rsp_out1(rsp_out1), .rsp_zero0(rsp_zero0), .rsp_zero1(rsp_zero1),
        .rsp_ack0(rsp_ack0), .rsp_ack1(rsp_ack1), .alu_ctrl(alu_ctrl), .alu_rs(alu_rs),
        .alu_rt(alu_rt), .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return {31'd0, $signed(a) < $signed(b)};
            4'b1100: return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    always_comb begin
        alu_out  = ref_alu(alu_ctrl, alu_rs, alu_rt);
        alu_zero = alu_out == 32'd0;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        req0 = 1'b1;
        req1 = 1'b1;
        #2;
        n_chk++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got %b%b exp 00", gnt0, gnt1); end
        n_chk++; if (busy !== 1'b0 || rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy_valid got %b%b%b exp 000", busy, rsp_valid0, rsp_valid1); end
        n_chk++; if (rsp_out0 !== 0 || rsp_out1 !== 0 || rsp_zero0 !== 0 || rsp_zero1 !== 0) begin n_fail++; $display("FAIL reset_rsp got %h %h %b %b exp 0", rsp_out0, rsp_out1, rsp_zero0, rsp_zero1); end
        n_chk++; if (alu_ctrl !== 0 || alu_rs !== 0 || alu_rt !== 0) begin n_fail++; $display("FAIL reset_alu got %h %h %h exp 0", alu_ctrl, alu_rs, alu_rt); end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single;
        tick();
        req0 = 1'b1; rs0 = 32'd5; rt0 = 32'd3; ctrl0 = 4'b0010;
        #1;
        n_chk++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL single_gnt got %b%b exp 10", gnt0, gnt1); end
        tick();
        req0 = 1'b0; rs0 = 32'hdead; rt0 = 32'hbeef; ctrl0 = 4'b0000;
        #1;
        n_chk++; if (alu_rs !== 32'd5 || alu_rt !== 32'd3 || alu_ctrl !== 4'b0010) begin n_fail++; $display("FAIL single_exec got %0d %0d %b exp 5 3 0010", alu_rs, alu_rt, alu_ctrl); end
        n_chk++; if (busy !== 1'b1 || rsp_valid0 !== 1'b0 || gnt0 !== 1'b0) begin n_fail++; $display("FAIL single_exec_flags got busy=%b v=%b g=%b exp 1 0 0", busy, rsp_valid0, gnt0); end
        tick();
        #1;
        n_chk++; if (rsp_valid0 !== 1'b1 || rsp_valid1 !== 1'b0 || rsp_out0 !== 32'd8 || rsp_zero0 !== 1'b0) begin n_fail++; $display("FAIL single_rsp got v=%b%b out=%0d z=%b exp 10 8 0", rsp_valid0, rsp_valid1, rsp_out0, rsp_zero0); end
        rsp_ack0 = 1'b1;
        tick();
        rsp_ack0 = 1'b0;
        #1;
        n_chk++; if (rsp_valid0 !== 1'b0 || busy !== 1'b0 || rsp_out0 !== 32'd8) begin n_fail++; $display("FAIL single_done got v=%b busy=%b out=%0d exp 0 0 8", rsp_valid0, busy, rsp_out0); end
    endtask

    task automatic test_tie;
        int k;
        logic g;
        do_reset();
        req0 = 1'b1; rs0 = 32'd1; rt0 = 32'd2; ctrl0 = 4'b0010;
        req1 = 1'b1; rs1 = 32'd7; rt1 = 32'd7; ctrl1 = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            #1;
            k = 0;
            while (!(gnt0 || gnt1) && k < 5) begin tick(); #1; k++; end
            n_chk++; if (!(gnt0 ^ gnt1)) begin n_fail++; $display("FAIL tie_grant_timeout got %b%b exp one grant", gnt0, gnt1); end
            g = gnt1;
            n_chk++; if (g !== 1'(i % 2)) begin n_fail++; $display("FAIL tie_order idx=%0d got %b exp %0d", i, g, i % 2); end
            tick();
            tick();
            #1;
            if (g) begin
                n_chk++; if (rsp_valid1 !== 1'b1 || rsp_out1 !== 32'd0 || rsp_zero1 !== 1'b1) begin n_fail++; $display("FAIL tie_sub got v=%b out=%0d z=%b exp 1 0 1", rsp_valid1, rsp_out1, rsp_zero1); end
            end else begin
                n_chk++; if (rsp_valid0 !== 1'b1 || rsp_out0 !== 32'd3 || rsp_zero0 !== 1'b0) begin n_fail++; $display("FAIL tie_add got v=%b out=%0d z=%b exp 1 3 0", rsp_valid0, rsp_out0, rsp_zero0); end
            end
            if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
            if (g) rsp_ack1 = 1'b1; else rsp_ack0 = 1'b1;
            tick();
            rsp_ack0 = 1'b0;
            rsp_ack1 = 1'b0;
        end
    endtask

    task automatic test_backpressure;
        req0 = 1'b1; rs0 = 32'd10; rt0 = 32'd20; ctrl0 = 4'b0010;
        tick();
        req0 = 1'b0;
        tick();
        req1 = 1'b1; rs1 = 32'd9; rt1 = 32'd4; ctrl1 = 4'b0110;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_chk++; if (rsp_valid0 !== 1'b1 || rsp_out0 !== 32'd30 || busy !== 1'b1 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL bp_hold cyc=%0d got v=%b out=%0d busy=%b g1=%b exp 1 30 1 0", i, rsp_valid0, rsp_out0, busy, gnt1); end
            tick();
        end
        rsp_ack0 = 1'b1;
        #1;
        n_chk++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL bp_early_gnt got %b exp 0", gnt1); end
        tick();
        rsp_ack0 = 1'b0;
        #1;
        n_chk++; if (gnt1 !== 1'b1 || rsp_valid0 !== 1'b0) begin n_fail++; $display("FAIL bp_next_gnt got g1=%b v0=%b exp 1 0", gnt1, rsp_valid0); end
        tick();
        req1 = 1'b0;
        tick();
        #1;
        n_chk++; if (rsp_valid1 !== 1'b1 || rsp_out1 !== 32'd5 || rsp_out0 !== 32'd30) begin n_fail++; $display("FAIL bp_req1_rsp got v=%b out1=%0d out0=%0d exp 1 5 30", rsp_valid1, rsp_out1, rsp_out0); end
        rsp_ack1 = 1'b1;
        tick();
        rsp_ack1 = 1'b0;
    endtask

    task automatic test_wrong_ack;
        req0 = 1'b1; rs0 = 32'hf0; rt0 = 32'h0f; ctrl0 = 4'b0001;
        tick();
        req0 = 1'b0;
        tick();
        req1 = 1'b1;
        rsp_ack1 = 1'b1;
        tick();
        rsp_ack1 = 1'b0;
        #1;
        n_chk++; if (rsp_valid0 !== 1'b1 || busy !== 1'b1 || rsp_out0 !== 32'hff || rsp_valid1 !== 1'b0) begin n_fail++; $display("FAIL wrong_ack got v0=%b busy=%b out=%h v1=%b exp 1 1 ff 0", rsp_valid0, busy, rsp_out0, rsp_valid1); end
        req1 = 1'b0;
        rsp_ack0 = 1'b1;
        tick();
        rsp_ack0 = 1'b0;
        #1;
        n_chk++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || busy !== 1'b0 || rsp_valid0 !== 1'b0) begin n_fail++; $display("FAIL dropped_req got g=%b%b busy=%b v0=%b exp 00 0 0", gnt0, gnt1, busy, rsp_valid0); end
        tick();
        #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dropped_req_idle got busy=%b exp 0", busy); end
    endtask

    task automatic test_reset_mid;
        req0 = 1'b1; rs0 = 32'd100; rt0 = 32'd1; ctrl0 = 4'b0010;
        tick();
        req0 = 1'b0;
        req1 = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_chk++; if (gnt0 !== 0 || gnt1 !== 0 || busy !== 0 || rsp_valid0 !== 0 || rsp_valid1 !== 0) begin n_fail++; $display("FAIL rmid_flags got g=%b%b busy=%b v=%b%b exp all 0", gnt0, gnt1, busy, rsp_valid0, rsp_valid1); end
        n_chk++; if (rsp_out0 !== 0 || rsp_out1 !== 0 || alu_rs !== 0 || alu_rt !== 0 || alu_ctrl !== 0) begin n_fail++; $display("FAIL rmid_data got %h %h %h %h %h exp 0", rsp_out0, rsp_out1, alu_rs, alu_rt, alu_ctrl); end
        req1 = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (rsp_valid0 !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_no_rsp cyc=%0d got v0=%b busy=%b exp 0 0", i, rsp_valid0, busy); end
            tick();
        end
        req1 = 1'b1; rs1 = 32'd6; rt1 = 32'd3; ctrl1 = 4'b0000;
        #1;
        n_chk++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL rmid_regrant got %b exp 1", gnt1); end
        tick();
        req1 = 1'b0;
        tick();
        #1;
        n_chk++; if (rsp_valid1 !== 1'b1 || rsp_out1 !== 32'd2) begin n_fail++; $display("FAIL rmid_rsp got v=%b out=%0d exp 1 2", rsp_valid1, rsp_out1); end
        rsp_ack1 = 1'b1;
        tick();
        rsp_ack1 = 1'b0;
    endtask

    task automatic test_random;
        logic [3:0]  ops [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011};
        logic [31:0] exp_out [2];
        logic        exp_zero [2];
        logic        pend [2];
        int          last_srv, win, dly;
        logic [31:0] e;
        do_reset();
        last_srv = 1;
        exp_out = '{32'd0, 32'd0};
        exp_zero = '{1'b0, 1'b0};
        pend = '{1'b0, 1'b0};
        for (int t = 0; t < 60; t++) begin
            if (!pend[0] && $urandom_range(0, 1) == 1) begin
                pend[0] = 1'b1; rs0 = $urandom; ctrl0 = ops[$urandom_range(0, 6)];
                rt0 = ($urandom_range(0, 3) == 0) ? rs0 : $urandom;
            end
            if (!pend[1] && $urandom_range(0, 1) == 1) begin
                pend[1] = 1'b1; rs1 = $urandom; ctrl1 = ops[$urandom_range(0, 6)];
                rt1 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
            end
            req0 = pend[0];
            req1 = pend[1];
            #1;
            if (!pend[0] && !pend[1]) begin
                n_chk++; if (gnt0 !== 0 || gnt1 !== 0 || busy !== 0) begin n_fail++; $display("FAIL rnd_idle t=%0d got g=%b%b busy=%b exp 000", t, gnt0, gnt1, busy); end
                tick();
                continue;
            end
            win = (pend[0] && pend[1]) ? 1 - last_srv : (pend[1] ? 1 : 0);
            n_chk++; if (gnt0 !== (win == 0) || gnt1 !== (win == 1)) begin n_fail++; $display("FAIL rnd_gnt t=%0d got %b%b exp winner %0d", t, gnt1, gnt0, win); end
            e = win ? ref_alu(ctrl1, rs1, rt1) : ref_alu(ctrl0, rs0, rt0);
            tick();
            pend[win] = 1'b0;
            req0 = pend[0];
            req1 = pend[1];
            #1;
            n_chk++; if (alu_ctrl !== (win ? ctrl1 : ctrl0) || alu_rs !== (win ? rs1 : rs0) || alu_rt !== (win ? rt1 : rt0) || busy !== 1'b1 || gnt0 !== 0 || gnt1 !== 0) begin n_fail++; $display("FAIL rnd_exec t=%0d got ctrl=%b rs=%h rt=%h busy=%b", t, alu_ctrl, alu_rs, alu_rt, busy); end
            tick();
            exp_out[win] = e;
            exp_zero[win] = e == 32'd0;
            dly = $urandom_range(0, 3);
            for (int d = 0; d <= dly; d++) begin
                #1;
                n_chk++; if (rsp_valid0 !== (win == 0) || rsp_valid1 !== (win == 1) || gnt0 !== 0 || gnt1 !== 0) begin n_fail++; $display("FAIL rnd_valid t=%0d got v=%b%b g=%b%b exp winner %0d", t, rsp_valid1, rsp_valid0, gnt1, gnt0, win); end
                n_chk++; if (rsp_out0 !== exp_out[0] || rsp_out1 !== exp_out[1] || rsp_zero0 !== exp_zero[0] || rsp_zero1 !== exp_zero[1]) begin n_fail++; $display("FAIL rnd_rsp t=%0d got %h/%b %h/%b exp %h/%b %h/%b", t, rsp_out0, rsp_zero0, rsp_out1, rsp_zero1, exp_out[0], exp_zero[0], exp_out[1], exp_zero[1]); end
                if (d == dly) begin
                    if (win == 1) rsp_ack1 = 1'b1; else rsp_ack0 = 1'b1;
                end else if ($urandom_range(0, 1) == 1) begin
                    if (win == 1) rsp_ack0 = 1'b1; else rsp_ack1 = 1'b1;
                end
                tick();
                rsp_ack0 = 1'b0;
                rsp_ack1 = 1'b0;
            end
            last_srv = win;
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_wrong_ack();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports req0/req1  input  1  requester 0/1 operation request, level, held until granted.
REQ-005 SHALL have ports rs0/rs1, rt0/rt1  input  32  requester operands (rt carries immediate where applicable).
REQ-006 SHALL have ports ctrl0/ctrl1  input  4  requester ALU control code, forwarded unmodified.
REQ-007 SHALL have ports gnt0/gnt1  output  1  one-cycle accept pulse; operands sampled on that edge.
REQ-008 SHALL have ports rsp_valid0/rsp_valid1  output  1  result available for the requester.
REQ-009 SHALL have ports rsp_out0/rsp_out1  output  32, rsp_zero0/rsp_zero1  output  1  registered result and zero flag.
REQ-010 SHALL have ports rsp_ack0/rsp_ack1  input  1  requester consumes its result.
REQ-011 SHALL have ports alu_ctrl  output  4, alu_rs  output  32, alu_rt  output  32  drive the shared ALU.
REQ-012 SHALL have ports alu_out  input  32, alu_zero  input  1  combinational ALU result and flag.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP; one transaction in flight at a time.
REQ-015 IDLE: if req0|req1, SHALL combinationally assert exactly one gnt, latch rs/rt/ctrl and owner ID at the edge, move to EXEC; else stay.
REQ-016 Arbitration SHALL be round-robin: single request wins; both requesting -> requester not served last; pointer updates on every grant.
REQ-017 gnt0/gnt1 SHALL never be high outside IDLE and never both high.
REQ-018 EXEC (exactly one cycle): alu_rs/alu_rt/alu_ctrl SHALL present latched operands; alu_out/alu_zero captured into result register at the edge; move to RESP.
REQ-019 alu_* outputs SHALL always come from the operand register (stable in all states), never from requester inputs directly.
REQ-020 RESP: rsp_valid of the owner only SHALL be high, rsp_out/rsp_zero stable; on owner's rsp_ack move to IDLE; ack from non-owner ignored.
REQ-021 rsp_out/rsp_zero of the non-owner SHALL hold their previous values; rsp_valid low outside RESP.
REQ-022 Latency: req in IDLE cycle N -> gnt in N, EXEC N+1, rsp_valid from N+2; ack in N+2 -> IDLE in N+3, next gnt earliest N+3.
REQ-023 A request dropped before grant SHALL be lost without side effects; requests during EXEC/RESP SHALL wait (no queueing beyond the level).
REQ-024 Ctrl codes SHALL be forwarded without decoding; result is whatever the ALU returns.

Reset
REQ-025 rst high SHALL immediately force IDLE, gnt*=0, rsp_valid*=0, rsp_out*=0, rsp_zero*=0, alu_ctrl/alu_rs/alu_rt=0, busy=0, pointer so requester 0 wins first tie.
REQ-026 Reset during EXEC or RESP SHALL abandon the transaction; no response delivered, requester must re-request.

Verification
REQ-027 Single: req0, rs0=5, rt0=3, ctrl0=0010 -> gnt0 cycle N, alu_rs=5/alu_rt=3 in N+1, rsp_valid0 N+2, rsp_out0=8, rsp_zero0=0.
REQ-028 Tie: req0 and req1 held after reset -> grant order 0,1,0,1; ALU SUB with rs1=rt1=7 returns rsp_out1=0, rsp_zero1=1.
REQ-029 Backpressure: withhold rsp_ack0 10 cycles -> rsp_valid0 and rsp_out0 stable, busy=1, req1 not granted until cycle after ack.
REQ-030 Wrong ack: in RESP for owner 0 pulse rsp_ack1 -> state stays RESP, rsp_valid0 remains 1.
REQ-031 Reset mid-op: assert rst during EXEC -> all outputs 0 asynchronously, no rsp_valid after release; fresh req1 granted in first IDLE cycle.
